// File: rtl/hostbus_pkg.sv
// rtl/hostbus_pkg.sv - shared opcodes, response codes and FSM states for the host bus master
//
// Purpose: constants used by hostbus_master.
// Ports: none (package).

package hostbus_pkg;

  // Command opcodes, cmd_word[DW+1:DW]
  localparam logic [1:0] OP_READ    = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_SETADDR = 2'b10;
  localparam logic [1:0] OP_BURST   = 2'b11;

  // Response codes, rsp_word[DW+1:DW]
  localparam logic [1:0] RSP_RDATA = 2'b00;
  localparam logic [1:0] RSP_WACK  = 2'b01;
  localparam logic [1:0] RSP_ADDR  = 2'b10;
  localparam logic [1:0] RSP_ERR   = 2'b11;

  // FSM states
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t XFER = 2'd1;
  localparam state_t RESP = 2'd2;

endpackage

// File: rtl/hostbus_timeout.sv
// rtl/hostbus_timeout.sv - loadable down-counter that flags an expired bus cycle
//
// Purpose: counts XFER cycles; expired is high in the TIMEOUT-th cycle after load drops.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   load        reload the counter (held while not transferring)
//   en          count down one per cycle
//   expired     counter has reached zero

module hostbus_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [TW-1:0] count;

  // Loaded with TIMEOUT-1 so that the first XFER cycle is cycle 1 and
  // zero is reached in cycle TIMEOUT.
  always_ff @(posedge clk) begin
    if (reset || load) begin
      count <= TW'(TIMEOUT - 1);
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/hostbus_master.sv
// rtl/hostbus_master.sv - host command word to Wishbone-classic bus master
//
// Purpose: decodes {opcode, payload} commands into bus cycles and returns responses.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   cmd_stb, cmd_word, cmd_busy     command input, ignored while busy
//   rsp_stb, rsp_word               one-cycle response pulse and held response word
//   bus_cyc, bus_stb, bus_we,
//   bus_addr, bus_wdata             Wishbone master outputs
//   bus_ack, bus_err, bus_rdata     Wishbone slave returns

module hostbus_master
  import hostbus_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 30,
  parameter int CW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_stb,
  input  logic [DW+1:0] cmd_word,
  output logic          cmd_busy,
  output logic          rsp_stb,
  output logic [DW+1:0] rsp_word,
  output logic          bus_cyc,
  output logic          bus_stb,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_ack,
  input  logic          bus_err,
  input  logic [DW-1:0] bus_rdata
);

  state_t        state;
  logic [AW-1:0] addr;
  logic          inc;
  logic [CW-1:0] beats_left;
  logic          expired;

  logic [1:0]    opcode;
  logic [DW-1:0] payload;
  logic [AW-1:0] setaddr_val;
  logic [CW-1:0] burst_cnt;

  assign opcode    = cmd_word[DW+1:DW];
  assign payload   = cmd_word[DW-1:0];
  assign burst_cnt = payload[CW-1:0];
  assign cmd_busy  = (state != IDLE);

  // Relative mode: adding the AW-bit field modulo 2^AW gives the same
  // result as adding its sign extension, so no explicit extension is needed.
  assign setaddr_val = payload[DW-1] ? (addr + payload[AW-1:0]) : payload[AW-1:0];

  hostbus_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .load    (state != XFER),
    .en      (state == XFER),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      addr       <= '0;
      inc        <= 1'b0;
      beats_left <= '0;
      bus_cyc    <= 1'b0;
      bus_stb    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      rsp_stb    <= 1'b0;
      rsp_word   <= '0;
    end else begin
      rsp_stb <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_stb) begin
            if (opcode == OP_SETADDR) begin
              inc      <= payload[DW-2];
              addr     <= setaddr_val;
              rsp_stb  <= 1'b1;
              rsp_word <= {RSP_ADDR, {(DW-AW){1'b0}}, setaddr_val};
            end else begin
              state    <= XFER;
              bus_cyc  <= 1'b1;
              bus_stb  <= 1'b1;
              bus_addr <= addr;
              bus_we   <= (opcode == OP_WRITE);
              if (opcode == OP_WRITE) begin
                bus_wdata <= payload;
              end
              // beats_left counts beats after the current one; count 0 means one word
              if ((opcode == OP_BURST) && (burst_cnt != '0)) begin
                beats_left <= burst_cnt - 1'b1;
              end else begin
                beats_left <= '0;
              end
            end
          end
        end

        XFER: begin
          if (bus_err || bus_ack || expired) begin
            state   <= RESP;
            bus_cyc <= 1'b0;
            bus_stb <= 1'b0;
            rsp_stb <= 1'b1;
            if (bus_err || !bus_ack) begin
              // err outranks ack; a timeout only lands here without ack
              rsp_word   <= {RSP_ERR, {(DW-AW){1'b0}}, bus_addr};
              beats_left <= '0;
            end else begin
              if (bus_we) begin
                rsp_word <= {RSP_WACK, {(DW-AW){1'b0}}, bus_addr};
              end else begin
                rsp_word <= {RSP_RDATA, bus_rdata};
              end
              addr <= addr + {{(AW-1){1'b0}}, inc};
            end
          end
        end

        RESP: begin
          if (beats_left != '0) begin
            state      <= XFER;
            bus_cyc    <= 1'b1;
            bus_stb    <= 1'b1;
            bus_addr   <= addr;
            beats_left <= beats_left - 1'b1;
          end else begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hostbus_master.sv
// tb/tb_hostbus_master.sv - directed self-checking bench for hostbus_master

module tb_hostbus_master;

  logic        clk;
  logic        reset;
  logic        cmd_stb;
  logic [33:0] cmd_word;
  logic        cmd_busy;
  logic        rsp_stb;
  logic [33:0] rsp_word;
  logic        bus_cyc;
  logic        bus_stb;
  logic        bus_we;
  logic [29:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic        bus_err;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;

  hostbus_master #(.DW(32), .AW(30), .CW(8), .TIMEOUT(255)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_stb   (cmd_stb),
    .cmd_word  (cmd_word),
    .cmd_busy  (cmd_busy),
    .rsp_stb   (rsp_stb),
    .rsp_word  (rsp_word),
    .bus_cyc   (bus_cyc),
    .bus_stb   (bus_stb),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_err   (bus_err),
    .bus_rdata (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents a command for one cycle; returns at the negedge after the accept edge.
  task automatic send_cmd(input logic [33:0] w);
    @(negedge clk);
    cmd_stb  = 1'b1;
    cmd_word = w;
    @(negedge clk);
    cmd_stb  = 1'b0;
    cmd_word = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({cmd_busy, rsp_stb, bus_cyc, bus_stb, bus_we} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b need 00000", {cmd_busy, rsp_stb, bus_cyc, bus_stb, bus_we});
    end
    checks++;
    if ({rsp_word, bus_addr, bus_wdata} !== '0) begin
      errors++; $display("FAIL reset_data got rsp=%h addr=%h wdata=%h need 0", rsp_word, bus_addr, bus_wdata);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_setaddr();
    send_cmd(34'h2_4000_0000);
    checks++;
    if (rsp_stb !== 1'b1 || rsp_word !== 34'h2_0000_0000) begin
      errors++; $display("FAIL setaddr_rsp got stb=%b word=%h need 1 200000000", rsp_stb, rsp_word);
    end
    checks++;
    if (cmd_busy !== 1'b0 || bus_cyc !== 1'b0) begin
      errors++; $display("FAIL setaddr_idle got busy=%b cyc=%b need 0 0", cmd_busy, bus_cyc);
    end
    @(negedge clk);
    checks++;
    if (rsp_stb !== 1'b0) begin
      errors++; $display("FAIL setaddr_pulse got stb=%b need 0", rsp_stb);
    end
  endtask

  task automatic test_write();
    send_cmd(34'h1_AABB_CCDD);
    checks++;
    if ({bus_cyc, bus_stb, bus_we, cmd_busy} !== 4'b1111 || bus_addr !== 30'h0 || bus_wdata !== 32'hAABB_CCDD) begin
      errors++; $display("FAIL write_bus got cyc/stb/we/busy=%b addr=%h wdata=%h need 1111 0 aabbccdd",
                         {bus_cyc, bus_stb, bus_we, cmd_busy}, bus_addr, bus_wdata);
    end
    // A command while busy must be dropped.
    cmd_stb  = 1'b1;
    cmd_word = 34'h2_0000_0123;
    @(negedge clk);
    cmd_stb  = 1'b0;
    checks++;
    if (rsp_stb !== 1'b0 || bus_cyc !== 1'b1) begin
      errors++; $display("FAIL write_ignore got stb=%b cyc=%b need 0 1", rsp_stb, bus_cyc);
    end
    @(negedge clk);
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    checks++;
    if (rsp_stb !== 1'b1 || rsp_word !== 34'h1_0000_0000 || bus_cyc !== 1'b0) begin
      errors++; $display("FAIL write_rsp got stb=%b word=%h cyc=%b need 1 100000000 0", rsp_stb, rsp_word, bus_cyc);
    end
    @(negedge clk);
    checks++;
    if (cmd_busy !== 1'b0) begin
      errors++; $display("FAIL write_idle got busy=%b need 0", cmd_busy);
    end
    send_cmd(34'h2_C000_0000);
    checks++;
    if (rsp_word !== 34'h2_0000_0001) begin
      errors++; $display("FAIL write_inc got %h need 200000001", rsp_word);
    end
  endtask

  task automatic test_read();
    send_cmd(34'h2_4000_0000);
    send_cmd(34'h0_0000_0000);
    checks++;
    if (bus_cyc !== 1'b1 || bus_we !== 1'b0 || bus_addr !== 30'h0) begin
      errors++; $display("FAIL read_bus got cyc=%b we=%b addr=%h need 1 0 0", bus_cyc, bus_we, bus_addr);
    end
    bus_ack   = 1'b1;
    bus_rdata = 32'hAABB_CCDD;
    @(negedge clk);
    bus_ack = 1'b0;
    checks++;
    if (rsp_stb !== 1'b1 || rsp_word !== 34'h0_AABB_CCDD) begin
      errors++; $display("FAIL read_rsp got stb=%b word=%h need 1 0aabbccdd", rsp_stb, rsp_word);
    end
    @(negedge clk);
  endtask

  task automatic test_burst();
    logic [29:0] exp_addr [4];
    exp_addr[0] = 30'h3FFF_FFFE;
    exp_addr[1] = 30'h3FFF_FFFF;
    exp_addr[2] = 30'h0;
    exp_addr[3] = 30'h1;
    send_cmd(34'h2_7FFF_FFFE);
    checks++;
    if (rsp_word !== 34'h2_3FFF_FFFE) begin
      errors++; $display("FAIL burst_setaddr got %h need 23ffffffe", rsp_word);
    end
    send_cmd(34'h3_0000_0004);
    for (int i = 0; i < 4; i++) begin
      int n = 0;
      while (!bus_cyc && n < 10) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (bus_cyc !== 1'b1 || bus_addr !== exp_addr[i] || cmd_busy !== 1'b1) begin
        errors++; $display("FAIL burst_beat%0d got cyc=%b addr=%h busy=%b need 1 %h 1", i, bus_cyc, bus_addr, cmd_busy, exp_addr[i]);
      end
      bus_ack   = 1'b1;
      bus_rdata = 32'h1000 + i;
      @(negedge clk);
      bus_ack = 1'b0;
      checks++;
      if (rsp_stb !== 1'b1 || rsp_word !== {2'b00, 32'h1000 + i} || cmd_busy !== 1'b1) begin
        errors++; $display("FAIL burst_rsp%0d got stb=%b word=%h busy=%b need 1 %h 1", i, rsp_stb, rsp_word, cmd_busy, 32'h1000 + i);
      end
      @(negedge clk);
    end
    checks++;
    if (cmd_busy !== 1'b0 || bus_cyc !== 1'b0) begin
      errors++; $display("FAIL burst_end got busy=%b cyc=%b need 0 0", cmd_busy, bus_cyc);
    end
  endtask

  task automatic test_burst_err();
    int seen_cyc = 0;
    send_cmd(34'h2_4000_0010);
    send_cmd(34'h3_0000_0003);
    bus_ack   = 1'b1;
    bus_rdata = 32'h55;
    @(negedge clk);
    bus_ack = 1'b0;
    checks++;
    if (rsp_stb !== 1'b1 || rsp_word !== 34'h0_0000_0055) begin
      errors++; $display("FAIL berr_beat1 got stb=%b word=%h need 1 000000055", rsp_stb, rsp_word);
    end
    @(negedge clk);
    checks++;
    if (bus_cyc !== 1'b1 || bus_addr !== 30'h11) begin
      errors++; $display("FAIL berr_beat2 got cyc=%b addr=%h need 1 11", bus_cyc, bus_addr);
    end
    bus_err = 1'b1;
    bus_ack = 1'b1;
    @(negedge clk);
    bus_err = 1'b0;
    bus_ack = 1'b0;
    checks++;
    if (rsp_stb !== 1'b1 || rsp_word !== 34'h3_0000_0011) begin
      errors++; $display("FAIL berr_rsp got stb=%b word=%h need 1 300000011", rsp_stb, rsp_word);
    end
    repeat (4) begin
      @(negedge clk);
      if (bus_cyc) seen_cyc++;
    end
    checks++;
    if (seen_cyc != 0 || cmd_busy !== 1'b0) begin
      errors++; $display("FAIL berr_no_beat3 got cyc_cycles=%0d busy=%b need 0 0", seen_cyc, cmd_busy);
    end
    send_cmd(34'h2_C000_0000);
    checks++;
    if (rsp_word !== 34'h2_0000_0011) begin
      errors++; $display("FAIL berr_addr got %h need 200000011", rsp_word);
    end
  endtask

  task automatic test_timeout();
    int cnt = 0;
    send_cmd(34'h0_0000_0000);
    while (bus_cyc && cnt < 400) begin
      cnt++;
      @(negedge clk);
    end
    checks++;
    if (cnt != 255) begin
      errors++; $display("FAIL timeout_len got %0d need 255", cnt);
    end
    checks++;
    if (rsp_stb !== 1'b1 || rsp_word !== 34'h3_0000_0011) begin
      errors++; $display("FAIL timeout_rsp got stb=%b word=%h need 1 300000011", rsp_stb, rsp_word);
    end
    @(negedge clk);
    // Ack in the final allowed cycle beats the timeout.
    send_cmd(34'h0_0000_0000);
    repeat (254) @(negedge clk);
    bus_ack   = 1'b1;
    bus_rdata = 32'hCAFE_0001;
    @(negedge clk);
    bus_ack = 1'b0;
    checks++;
    if (rsp_stb !== 1'b1 || rsp_word !== 34'h0_CAFE_0001) begin
      errors++; $display("FAIL timeout_ack_wins got stb=%b word=%h need 1 0cafe0001", rsp_stb, rsp_word);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int seen_rsp = 0;
    send_cmd(34'h0_0000_0000);
    @(negedge clk);
    reset   = 1'b1;
    bus_ack = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    bus_ack = 1'b0;
    checks++;
    if (bus_cyc !== 1'b0 || bus_stb !== 1'b0 || rsp_stb !== 1'b0 || cmd_busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid got cyc=%b stb=%b rsp=%b busy=%b need 0 0 0 0", bus_cyc, bus_stb, rsp_stb, cmd_busy);
    end
    repeat (3) begin
      @(negedge clk);
      if (rsp_stb) seen_rsp++;
    end
    checks++;
    if (seen_rsp != 0) begin
      errors++; $display("FAIL reset_mid_rsp got %0d pulses need 0", seen_rsp);
    end
  endtask

  initial begin
    reset     = 1'b1;
    cmd_stb   = 1'b0;
    cmd_word  = '0;
    bus_ack   = 1'b0;
    bus_err   = 1'b0;
    bus_rdata = '0;
    test_reset();
    test_setaddr();
    test_write();
    test_read();
    test_burst();
    test_burst_err();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
